sample_frame_buffer: RTL

- Ping-pong capture buffer that sits directly upstream of `fft_256`.
- Accumulates a stream of audio samples into 256-sample frames and freezes a complete frame onto `time_samples`.
- Pulses `start` to launch the FFT, then holds the frame stable until the FFT reports `done`; meanwhile the next frame fills the other bank.

---
 rtl/sample_frame_buffer_if.sv | 23 ++
 rtl/sample_frame_buffer.sv | 96 +++++++++
 2 files changed

// File: rtl/sample_frame_buffer_if.sv
// Sample stream in, frozen frame plus FFT launch handshake out, for sample_frame_buffer.
interface sample_frame_buffer_if #(
    parameter int WIDTH = 12,
    parameter int N     = 256
);
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic             fft_done;
    logic             start;
    logic [WIDTH-1:0] time_samples [0:N-1];
    logic             busy;
    logic             overrun;

    modport master (
        output sample_in, sample_valid, fft_done,
        input  start, time_samples, busy, overrun
    );

    modport slave (
        input  sample_in, sample_valid, fft_done,
        output start, time_samples, busy, overrun
    );
endinterface

// File: rtl/sample_frame_buffer.sv
// Ping-pong N-sample capture buffer feeding fft_256: one bank fills while the other is held for the FFT.
// Optional ADC_OFFSET_EN: incoming samples are offset-binary and get their MSB inverted before storage.
module sample_frame_buffer #(
    parameter int WIDTH = 12,
    parameter int N     = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    sample_frame_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY
    } state_t;

    state_t            state;
    logic              bank_sel;
    logic [PTR_W-1:0]  wr_ptr;
    logic [WIDTH-1:0]  bank [0:1][0:N-1];
    logic [WIDTH-1:0]  wr_data;
    logic              frame_done;

`ifdef ADC_OFFSET_EN
    assign wr_data = {~bus.sample_in[WIDTH-1], bus.sample_in[WIDTH-2:0]};
`else
    assign wr_data = bus.sample_in;
`endif

    assign frame_done = bus.sample_valid && (wr_ptr == PTR_W'(N - 1));

    // Fill side: the pointer wraps on every completion, so a discarded frame is simply overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            bank   <= '{default: '0};
        end else if (bus.sample_valid) begin
            bank[bank_sel][wr_ptr] <= wr_data;
            wr_ptr                 <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bank_sel    <= 1'b0;
            bus.start   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            bus.start   <= 1'b0;
            bus.overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_done) begin
                        bank_sel  <= ~bank_sel;
                        state     <= START;
                        bus.start <= 1'b1;
                        bus.busy  <= 1'b1;
                    end
                end
                START: begin
                    state <= BUSY;
                    if (frame_done) bus.overrun <= 1'b1;
                end
                BUSY: begin
                    // Done coinciding with a completion behaves as IDLE: swap and relaunch at once.
                    if (bus.fft_done) begin
                        if (frame_done) begin
                            bank_sel  <= ~bank_sel;
                            state     <= START;
                            bus.start <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else if (frame_done) begin
                        bus.overrun <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            bus.time_samples[i] = bank[~bank_sel][i];
        end
    end
endmodule
